// File: rtl/sync_sp_ram_rmw_master.sv
// Request initiator for the single-port SRAM wrappers. Full-word writes go straight through.
// Partial-byte writes become a read of the old word followed by a merged write, because the
// wrappers ignore byte enables. Requests are serialised, so no hazard logic is needed.
module sync_sp_ram_rmw_master #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  // request port
  input  logic                  ReqValid_SI,
  output logic                  ReqReady_SO,
  input  logic                  ReqWe_SI,
  input  logic [DATA_W/8-1:0]   ReqBe_SI,
  input  logic [ADDR_W-1:0]     ReqAddr_DI,
  input  logic [DATA_W-1:0]     ReqWData_DI,
  // read response port
  output logic                  RspValid_SO,
  input  logic                  RspReady_SI,
  output logic [DATA_W-1:0]     RspRData_DO,
  // SRAM wrapper pins
  output logic                  CSel_SO,
  output logic                  WrEn_SO,
  output logic [DATA_W/8-1:0]   BEn_SO,
  output logic [ADDR_W-1:0]     Addr_DO,
  output logic [DATA_W-1:0]     WrData_DO,
  input  logic [DATA_W-1:0]     RdData_DI,
  // statistics
  output logic [15:0]           RmwCnt_DO
);

  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRmwWr = 2'd1,
    StRdCap = 2'd2,
    StRsp   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [15:0]         rmw_cnt_q;

  logic                req_accept;
  logic                be_all;
  logic                be_none;
  logic [DATA_W-1:0]   merged_data;

  // Ready is purely a function of state and reset so it never loops back through the
  // requester's valid or the consumer's ready.
  assign ReqReady_SO = (state_q == StIdle) && Rst_RBI;
  assign req_accept  = ReqValid_SI && ReqReady_SO;
  assign be_all      = &ReqBe_SI;
  assign be_none     = ~|ReqBe_SI;

  assign RspValid_SO = (state_q == StRsp);
  assign RspRData_DO = rdata_q;
  assign RmwCnt_DO   = rmw_cnt_q;
  assign BEn_SO      = '1;

  // Merge the captured write bytes over the old word returned by the RMW read.
  always_comb begin
    merged_data = RdData_DI;
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (be_q[i]) begin
        merged_data[i*8 +: 8] = wdata_q[i*8 +: 8];
      end
    end
  end

  // Next-state and SRAM pin drive; captured registers feed the pins when idle to limit toggling.
  always_comb begin
    state_d   = state_q;
    CSel_SO   = 1'b0;
    WrEn_SO   = 1'b0;
    Addr_DO   = addr_q;
    WrData_DO = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_accept) begin
          Addr_DO = ReqAddr_DI;
          if (!ReqWe_SI) begin
            CSel_SO = 1'b1;
            state_d = StRdCap;
          end else if (be_all) begin
            CSel_SO   = 1'b1;
            WrEn_SO   = 1'b1;
            WrData_DO = ReqWData_DI;
          end else if (!be_none) begin
            // Old-word read for the read-modify-write.
            CSel_SO = 1'b1;
            state_d = StRmwWr;
          end
        end
      end
      StRmwWr: begin
        CSel_SO   = 1'b1;
        WrEn_SO   = 1'b1;
        WrData_DO = merged_data;
        state_d   = StIdle;
      end
      StRdCap: begin
        state_d = StRsp;
      end
      StRsp: begin
        if (RspReady_SI) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture request fields on every accepted request.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (req_accept) begin
      addr_q  <= ReqAddr_DI;
      wdata_q <= ReqWData_DI;
      be_q    <= ReqBe_SI;
    end
  end

  // Register SRAM read data one cycle after the read access; held while the response waits.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      rdata_q <= '0;
    end else if (state_q == StRdCap) begin
      rdata_q <= RdData_DI;
    end
  end

  // Saturating count of completed read-modify-write operations.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      rmw_cnt_q <= '0;
    end else if ((state_q == StRmwWr) && (rmw_cnt_q != 16'hFFFF)) begin
      rmw_cnt_q <= rmw_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_sync_sp_ram_rmw_master.sv
// Bench for sync_sp_ram_rmw_master: behavioural SRAM, shadow memory and a queue of expected
// read responses filled as reads are issued.
module tb_sync_sp_ram_rmw_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [7:0]  req_be = 8'h00;
  logic [7:0]  req_addr = 8'h00;
  logic [63:0] req_wdata = 64'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_rdata;
  logic        csel;
  logic        wren;
  logic [7:0]  ben;
  logic [7:0]  sram_addr;
  logic [63:0] sram_wdata;
  logic [63:0] sram_rd;
  logic [15:0] rmw_cnt;

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int unsigned cs_cnt = 0;
  int unsigned we_cnt = 0;
  logic [15:0] exp_cnt = 16'h0;
  logic [63:0] shadow [256];
  logic [63:0] sram_mem [256];
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  sync_sp_ram_rmw_master #(.DATA_W(64), .ADDR_W(8)) dut (
    .Clk_CI      (clk),
    .Rst_RBI     (rst_n),
    .ReqValid_SI (req_valid),
    .ReqReady_SO (req_ready),
    .ReqWe_SI    (req_we),
    .ReqBe_SI    (req_be),
    .ReqAddr_DI  (req_addr),
    .ReqWData_DI (req_wdata),
    .RspValid_SO (rsp_valid),
    .RspReady_SI (rsp_ready),
    .RspRData_DO (rsp_rdata),
    .CSel_SO     (csel),
    .WrEn_SO     (wren),
    .BEn_SO      (ben),
    .Addr_DO     (sram_addr),
    .WrData_DO   (sram_wdata),
    .RdData_DI   (sram_rd),
    .RmwCnt_DO   (rmw_cnt)
  );

  // Behavioural SRAM wrapper: whole-word writes, read data the cycle after the access.
  always @(posedge clk) begin
    if (csel) begin
      if (wren) sram_mem[sram_addr] <= sram_wdata;
      else sram_rd <= sram_mem[sram_addr];
    end
  end

  // Cycle and SRAM-activity counters.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (csel) cs_cnt <= cs_cnt + 1;
    if (csel && wren) we_cnt <= we_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Drive one request and wait (bounded) for acceptance; updates the bench model on accept.
  task automatic issue(input logic we, input logic [7:0] be, input logic [7:0] addr,
                       input logic [63:0] wd, output int unsigned acc_cyc);
    int n = 0;
    acc_cyc = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wd;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!req_ready) begin
      fails++;
      $display("FAIL issue_timeout: ready=%b required 1 within 50 cycles", req_ready);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      req_valid = 1'b0;
      if (!we) begin
        exp_q.push_back(shadow[addr]);
      end else begin
        for (int i = 0; i < 8; i++)
          if (be[i]) shadow[addr][i*8 +: 8] = wd[i*8 +: 8];
        if (be != 8'h00 && be != 8'hFF && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      end
    end
  endtask

  // Wait (bounded) for a response and compare it against the oldest expected read.
  task automatic get_rsp(input string name, output int unsigned waits);
    logic [63:0] exp;
    waits = 0;
    @(negedge clk);
    while (!rsp_valid && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    tests++;
    if (!rsp_valid || exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s_timeout: rsp_valid=%b queued=%0d", name, rsp_valid, exp_q.size());
    end else begin
      exp = exp_q.pop_front();
      if (rsp_rdata !== exp) begin
        fails++;
        $display("FAIL %s: rdata=%h required %h", name, rsp_rdata, exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({req_ready, csel, wren, rsp_valid} !== 4'b0000 || rsp_rdata !== 64'h0 ||
        rmw_cnt !== 16'h0 || ben !== 8'hFF) begin
      fails++;
      $display("FAIL reset_values: ready=%b csel=%b wren=%b rspv=%b rdata=%h cnt=%h ben=%h required 0,0,0,0,0,0,ff",
               req_ready, csel, wren, rsp_valid, rsp_rdata, rmw_cnt, ben);
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_full_write_read();
    int unsigned a, w, c0, w0;
    c0 = cs_cnt; w0 = we_cnt;
    issue(1'b1, 8'hFF, 8'h10, 64'h0123456789ABCDEF, a);
    tests++;
    if (cs_cnt - c0 != 1 || we_cnt - w0 != 1 || sram_mem[8'h10] !== 64'h0123456789ABCDEF) begin
      fails++;
      $display("FAIL full_write: cs=%0d we=%0d mem=%h required 1 1 0123456789abcdef",
               cs_cnt - c0, we_cnt - w0, sram_mem[8'h10]);
    end
    issue(1'b0, 8'h00, 8'h10, 64'h0, a);
    get_rsp("full_readback", w);
    tests++;
    if (w != 1) begin
      fails++;
      $display("FAIL read_latency: valid after %0d idle negedges required 1", w);
    end
    tests++;
    if (rmw_cnt !== exp_cnt || exp_cnt !== 16'h0) begin
      fails++;
      $display("FAIL full_write_cnt: cnt=%h required 0000", rmw_cnt);
    end
  endtask

  task automatic test_partial_write();
    int unsigned a, w, c0, w0;
    issue(1'b1, 8'hFF, 8'h20, 64'hFFFFFFFFFFFFFFFF, a);
    c0 = cs_cnt; w0 = we_cnt;
    issue(1'b1, 8'h0F, 8'h20, 64'h0, a);
    @(negedge clk);
    tests++;
    if ({req_ready, csel, wren} !== 3'b011 || sram_addr !== 8'h20 ||
        sram_wdata !== 64'hFFFFFFFF00000000) begin
      fails++;
      $display("FAIL rmw_write_cycle: ready=%b csel=%b wren=%b addr=%h wdata=%h required 0 1 1 20 ffffffff00000000",
               req_ready, csel, wren, sram_addr, sram_wdata);
    end
    @(negedge clk);
    tests++;
    if (cs_cnt - c0 != 2 || we_cnt - w0 != 1 || rmw_cnt !== 16'h0001) begin
      fails++;
      $display("FAIL rmw_cycles: cs=%0d we=%0d cnt=%h required 2 1 0001",
               cs_cnt - c0, we_cnt - w0, rmw_cnt);
    end
    issue(1'b0, 8'h00, 8'h20, 64'h0, a);
    get_rsp("partial_readback", w);
  endtask

  task automatic test_backpressure();
    int unsigned a, n;
    logic [63:0] held, exp;
    rsp_ready = 1'b0;
    issue(1'b0, 8'h00, 8'h10, 64'h0, a);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    held = rsp_rdata;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin
        req_valid = 1'b1; req_we = 1'b1; req_be = 8'hFF; req_addr = 8'h40;
        req_wdata = 64'hDEADBEEFCAFEF00D;
      end
      tests++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== held || req_ready !== 1'b0) begin
        fails++;
        $display("FAIL backpressure_hold[%0d]: rspv=%b rdata=%h ready=%b required 1 %h 0",
                 k, rsp_valid, rsp_rdata, req_ready, held);
      end
      @(negedge clk);
    end
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    tests++;
    if (held !== exp) begin
      fails++;
      $display("FAIL backpressure_data: rdata=%h required %h", held, exp);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1 || csel !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL accept_after_handshake: ready=%b csel=%b rspv=%b required 1 1 0",
               req_ready, csel, rsp_valid);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    shadow[8'h40] = 64'hDEADBEEFCAFEF00D;
    issue(1'b0, 8'h00, 8'h40, 64'h0, a);
    get_rsp("pending_write_readback", n);
  endtask

  task automatic test_null_write();
    int unsigned a, w, c0;
    issue(1'b1, 8'hFF, 8'h30, 64'hAAAAAAAAAAAAAAAA, a);
    c0 = cs_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_be = 8'h00; req_addr = 8'h30;
    req_wdata = 64'h5555555555555555;
    #1;
    tests++;
    if (req_ready !== 1'b1 || csel !== 1'b0) begin
      fails++;
      $display("FAIL null_write_cycle: ready=%b csel=%b required 1 0", req_ready, csel);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1 || cs_cnt != c0) begin
      fails++;
      $display("FAIL null_write_idle: ready=%b cs=%0d required 1 0", req_ready, cs_cnt - c0);
    end
    issue(1'b0, 8'h00, 8'h30, 64'h0, a);
    get_rsp("null_write_readback", w);
  endtask

  task automatic test_reset_mid_op();
    int unsigned a, n, w0;
    logic [63:0] old;
    issue(1'b1, 8'hFF, 8'h50, 64'h1122334455667788, a);
    old = shadow[8'h50];
    issue(1'b1, 8'h01, 8'h50, 64'hFFFFFFFFFFFFFFFF, a);
    w0 = we_cnt;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({req_ready, csel, wren, rsp_valid} !== 4'b0000 || rmw_cnt !== 16'h0 ||
        rsp_rdata !== 64'h0) begin
      fails++;
      $display("FAIL reset_in_rmw: ready=%b csel=%b wren=%b rspv=%b cnt=%h rdata=%h required all 0",
               req_ready, csel, wren, rsp_valid, rmw_cnt, rsp_rdata);
    end
    shadow[8'h50] = old;
    exp_cnt = 16'h0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if (we_cnt != w0) begin
      fails++;
      $display("FAIL reset_in_rmw_wren: write pulses=%0d required 0", we_cnt - w0);
    end
    issue(1'b0, 8'h00, 8'h50, 64'h0, a);
    get_rsp("reset_rmw_readback", n);
    // Reset while the response is waiting discards it.
    rsp_ready = 1'b0;
    issue(1'b0, 8'h00, 8'h50, 64'h0, a);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 64'h0) begin
      fails++;
      $display("FAIL reset_in_rsp: rspv=%b rdata=%h required 0 0", rsp_valid, rsp_rdata);
    end
    void'(exp_q.pop_front());
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    int unsigned a [4];
    int unsigned p0, p1, w;
    for (int i = 0; i < 4; i++)
      issue(1'b1, 8'hFF, 8'h70 + 8'(i), {$urandom, $urandom}, a[i]);
    tests++;
    if (a[3] - a[0] != 3) begin
      fails++;
      $display("FAIL full_write_throughput: span=%0d cycles required 3", a[3] - a[0]);
    end
    issue(1'b1, 8'hA5, 8'h70, {$urandom, $urandom}, p0);
    issue(1'b1, 8'h3C, 8'h71, {$urandom, $urandom}, p1);
    tests++;
    if (p1 - p0 != 2) begin
      fails++;
      $display("FAIL partial_write_throughput: span=%0d cycles required 2", p1 - p0);
    end
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 8'h00, 8'h70 + 8'(i), 64'h0, w);
      get_rsp("b2b_readback", w);
    end
  endtask

  task automatic test_saturation();
    int unsigned a;
    @(negedge clk);
    force dut.rmw_cnt_q = 16'hFFFD;
    @(posedge clk);
    @(negedge clk);
    release dut.rmw_cnt_q;
    exp_cnt = 16'hFFFD;
    for (int k = 0; k < 4; k++) begin
      issue(1'b1, 8'h81, 8'h60, {$urandom, $urandom}, a);
      @(negedge clk);
      @(negedge clk);
      tests++;
      if (rmw_cnt !== exp_cnt) begin
        fails++;
        $display("FAIL rmw_saturation[%0d]: cnt=%h required %h", k, rmw_cnt, exp_cnt);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = 64'h0;
    test_reset();
    test_full_write_read();
    test_partial_write();
    test_backpressure();
    test_null_write();
    test_reset_mid_op();
    test_back_to_back();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
